// File: rtl/imem_fetch_responder_if.sv
// imem_fetch_responder_if: fetch-side handshake and byte-wide memory bus of the instruction fetch responder.
interface imem_fetch_responder_if;
    logic        req;
    logic [15:0] addr;
    logic        flush;
    logic [15:0] irnew;
    logic        irvalid;
    logic        busy;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    modport slave (input req, addr, flush, mem_data, output irnew, irvalid, busy, mem_addr, mem_rd);
    modport master (output req, addr, flush, mem_data, input irnew, irvalid, busy, mem_addr, mem_rd);
endinterface

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: fetches a 16-bit little-endian instruction word as two byte reads with wait states.
// Optional IMEM_LAST_WORD_HIT_EN re-delivers the last completed word without a bus cycle.
module imem_fetch_responder #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [15:0] RESET_IR    = 16'h0000
) (
    input logic clk,
    input logic rst,
    imem_fetch_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, DONE} state_e;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [14:0] w_q, w_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] irnew_q, irnew_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        hit;
`ifdef IMEM_LAST_WORD_HIT_EN
    logic        hit_vld_q, hit_vld_d;
    logic [14:0] hit_addr_q, hit_addr_d;
`endif
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        w_d        = w_q;
        lo_d       = lo_q;
        irnew_d    = irnew_q;
        mem_addr_d = mem_addr_q;
        hit        = 1'b0;
`ifdef IMEM_LAST_WORD_HIT_EN
        hit_vld_d  = hit_vld_q & ~bus.flush;
        hit_addr_d = hit_addr_q;
        hit        = hit_vld_q && (bus.addr[15:1] == hit_addr_q);
`endif
        case (state_q)
            IDLE: if (bus.req && !bus.flush) begin
                w_d = bus.addr[15:1];
                if (hit) begin
                    state_d = DONE;
                end else begin
                    state_d    = RD_LO;
                    mem_addr_d = {bus.addr[15:1], 1'b0};
                end
            end
            RD_LO: if (bus.flush) begin
                state_d = IDLE;
            end else if (wcnt_q != 4'd0) begin
                wcnt_d = wcnt_q - 4'd1;
            end else begin
                lo_d       = bus.mem_data;
                state_d    = RD_HI;
                mem_addr_d = {w_q, 1'b1};
            end
            RD_HI: if (bus.flush) begin
                state_d = IDLE;
            end else if (wcnt_q != 4'd0) begin
                wcnt_d = wcnt_q - 4'd1;
            end else begin
                irnew_d = {bus.mem_data, lo_q};
                state_d = DONE;
`ifdef IMEM_LAST_WORD_HIT_EN
                hit_vld_d  = 1'b1;
                hit_addr_d = w_q;
`endif
            end
            default: state_d = IDLE;
        endcase
        // every state entry restarts the per-access wait count
        if (state_d != state_q) wcnt_d = WAIT_LOAD;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            w_q        <= '0;
            lo_q       <= '0;
            irnew_q    <= RESET_IR;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            w_q        <= w_d;
            lo_q       <= lo_d;
            irnew_q    <= irnew_d;
            mem_addr_q <= mem_addr_d;
        end
    end
`ifdef IMEM_LAST_WORD_HIT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_vld_q  <= 1'b0;
            hit_addr_q <= '0;
        end else begin
            hit_vld_q  <= hit_vld_d;
            hit_addr_q <= hit_addr_d;
        end
    end
`endif
    assign bus.irnew    = irnew_q;
    assign bus.irvalid  = (state_q == DONE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.mem_rd   = (state_q == RD_LO) || (state_q == RD_HI);
    assign bus.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: two responders (0 and 2 wait states) checked against a cycle-age reference model.
module tb_imem_fetch_responder;
`ifdef IMEM_LAST_WORD_HIT_EN
    localparam bit HIT = 1'b1;
`else
    localparam bit HIT = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  mem [65536];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    imem_fetch_responder_if b0 ();
    imem_fetch_responder_if b2 ();
    assign b0.req = req;
    assign b0.addr = addr;
    assign b0.flush = flush;
    assign b0.mem_data = mem[b0.mem_addr];
    assign b2.req = req;
    assign b2.addr = addr;
    assign b2.flush = flush;
    assign b2.mem_data = mem[b2.mem_addr];

    imem_fetch_responder #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    imem_fetch_responder #(.WAIT_CYCLES(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

    logic [15:0] o_ir [2];
    logic [15:0] o_ma [2];
    logic        o_vld [2];
    logic        o_busy [2];
    logic        o_rd [2];
    assign o_ir[0] = b0.irnew;    assign o_ir[1] = b2.irnew;
    assign o_ma[0] = b0.mem_addr; assign o_ma[1] = b2.mem_addr;
    assign o_vld[0] = b0.irvalid; assign o_vld[1] = b2.irvalid;
    assign o_busy[0] = b0.busy;   assign o_busy[1] = b2.busy;
    assign o_rd[0] = b0.mem_rd;   assign o_rd[1] = b2.mem_rd;

    // model: age = cycles since the accepting edge; 1..L low byte, L+1..2L high byte, 2L+1 delivery
    int          L [2] = '{1, 3};
    int          age [2] = '{0, 0};
    logic [14:0] w [2];
    logic [15:0] ir [2];
    logic [15:0] ma [2];
    logic        hv [2];
    logic [14:0] ha [2];
    int          cyc = 0;
    int          lat [2];
    int          nvld [2];
    int          nrd [2];

    typedef struct {
        logic [15:0] a;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] word;
    } vec_t;
    vec_t tv [4];

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, i, act, exp);
        end
    endtask

    task automatic step(input int i);
        int l2;
        l2 = 2 * L[i];
        if (!rst) begin
            age[i] = 0; ir[i] = 16'h0000; ma[i] = 16'h0000; hv[i] = 1'b0;
        end else begin
            if (age[i] == 0) begin
                if (req && !flush) begin
                    w[i] = addr[15:1];
                    if (HIT && hv[i] && ha[i] == w[i]) age[i] = l2 + 1;
                    else begin
                        age[i] = 1;
                        ma[i] = {w[i], 1'b0};
                    end
                end
            end else if (age[i] <= l2) begin
                if (flush) age[i] = 0;
                else begin
                    age[i]++;
                    if (age[i] == L[i] + 1) ma[i] = {w[i], 1'b1};
                    if (age[i] == l2 + 1) begin
                        ir[i] = {mem[{w[i], 1'b1}], mem[{w[i], 1'b0}]};
                        hv[i] = 1'b1;
                        ha[i] = w[i];
                    end
                end
            end else age[i] = 0;
            if (flush) hv[i] = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 2; i++) step(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("irnew", i, o_ir[i], ir[i]);
            chk("irvalid", i, 16'(o_vld[i]), 16'(age[i] == 2 * L[i] + 1));
            chk("busy", i, 16'(o_busy[i]), 16'(age[i] != 0));
            chk("mem_rd", i, 16'(o_rd[i]), 16'(age[i] >= 1 && age[i] <= 2 * L[i]));
            chk("mem_addr", i, o_ma[i], ma[i]);
            if (o_vld[i]) begin
                nvld[i]++;
                if (lat[i] < 0) lat[i] = cyc;
            end
            if (o_rd[i]) nrd[i]++;
        end
        cyc++;
    endtask

    task automatic clr_stats();
        cyc = 1;
        lat = '{-1, -1};
        nvld = '{0, 0};
        nrd = '{0, 0};
    endtask

    task automatic fetch(input logic [15:0] a);
        clr_stats();
        addr = a;
        req = 1'b1;
        cycle();
        req = 1'b0;
        for (int k = 0; k < 40 && (lat[0] < 0 || lat[1] < 0); k++) cycle();
        cycle();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        tv[0] = '{16'h0011, 8'h34, 8'h12, 16'h1234};
        tv[1] = '{16'hFFFE, 8'hCD, 8'hAB, 16'hABCD};
        tv[2] = '{16'h0020, 8'h78, 8'h56, 16'h5678};
        tv[3] = '{16'h1235, 8'hEF, 8'hBE, 16'hBEEF};
        clr_stats();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        for (int i = 0; i < 2; i++) begin
            chk("rst_irnew", i, o_ir[i], 16'h0000);
            chk("rst_busy", i, 16'(o_busy[i]), 16'h0);
            chk("rst_mem_addr", i, o_ma[i], 16'h0000);
        end

        for (int t = 0; t < 4; t++) begin
            mem[{tv[t].a[15:1], 1'b0}] = tv[t].lo;
            mem[{tv[t].a[15:1], 1'b1}] = tv[t].hi;
            fetch(tv[t].a);
            for (int i = 0; i < 2; i++) begin
                chk("tbl_word", i, o_ir[i], tv[t].word);
                chk("tbl_latency", i, 16'(lat[i]), 16'(2 * L[i] + 1));
                chk("tbl_rd_cycles", i, 16'(nrd[i]), 16'(2 * L[i]));
                chk("tbl_valid_count", i, 16'(nvld[i]), 16'd1);
            end
        end

        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'h12;
        addr = 16'h0010;
        req = 1'b1;
        cycle();
        req = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        for (int i = 0; i < 2; i++) begin
            chk("midrd_irnew", i, o_ir[i], 16'h0000);
            chk("midrd_irvalid", i, 16'(o_vld[i]), 16'h0);
            chk("midrd_busy", i, 16'(o_busy[i]), 16'h0);
            chk("midrd_mem_rd", i, 16'(o_rd[i]), 16'h0);
        end

        fetch(16'h0020);
        clr_stats();
        addr = 16'h0010;
        req = 1'b1;
        cycle();
        req = 1'b0;
        repeat (4) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid_count", 1, 16'(nvld[1]), 16'd0);
        chk("flush_irnew", 1, o_ir[1], 16'h5678);
        chk("flush_busy", 1, 16'(o_busy[1]), 16'h0);
        fetch(16'h0020);
        for (int i = 0; i < 2; i++) begin
            chk("after_flush_word", i, o_ir[i], 16'h5678);
            chk("after_flush_latency", i, 16'(lat[i]), 16'(2 * L[i] + 1));
        end

        clr_stats();
        addr = 16'h0040;
        req = 1'b1;
        flush = 1'b1;
        cycle();
        req = 1'b0;
        flush = 1'b0;
        repeat (3) cycle();
        for (int i = 0; i < 2; i++) begin
            chk("reqflush_rd_cycles", i, 16'(nrd[i]), 16'd0);
            chk("reqflush_busy", i, 16'(o_busy[i]), 16'h0);
        end

        clr_stats();
        addr = 16'h0050;
        req = 1'b1;
        repeat (7) cycle();
        req = 1'b0;
        cycle();
        chk("busyreq_valid_count", 1, 16'(nvld[1]), 16'd1);
        chk("busyreq_busy", 1, 16'(o_busy[1]), 16'h0);
        repeat (8) cycle();

        fetch(16'h0010);
        for (int i = 0; i < 2; i++) chk("hit_first_latency", i, 16'(lat[i]), 16'(2 * L[i] + 1));
        fetch(16'h0010);
        for (int i = 0; i < 2; i++) begin
            chk("hit_word", i, o_ir[i], 16'h1234);
            chk("hit_latency", i, 16'(lat[i]), HIT ? 16'd1 : 16'(2 * L[i] + 1));
            chk("hit_rd_cycles", i, 16'(nrd[i]), HIT ? 16'd0 : 16'(2 * L[i]));
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        fetch(16'h0010);
        for (int i = 0; i < 2; i++) begin
            chk("postflush_latency", i, 16'(lat[i]), 16'(2 * L[i] + 1));
            chk("postflush_rd_cycles", i, 16'(nrd[i]), 16'(2 * L[i]));
        end

        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 99) != 0);
            req = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 9) == 0);
            addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0010 + 16'($urandom_range(0, 5));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
